booth_controller: RTL

BOOTH_CONTROLLER -- requirements
Module: booth_controller

---
 rtl/booth_controller.sv | 80 ++++++++
 1 files changed

// File: rtl/booth_controller.sv
// booth_controller: control FSM for a radix-2 Booth multiplier datapath.
// Define BOOTH_ABORT_EN to add the abort input and the aborted status pulse.
module booth_controller #(
    parameter int N = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic q0,
    input  logic qm1,
    input  logic eqz,
`ifdef BOOTH_ABORT_EN
    input  logic abort,
    output logic aborted,
`endif
    output logic ldA,
    output logic ldQ,
    output logic ldM,
    output logic clrA,
    output logic clrQ,
    output logic clrff,
    output logic sftA,
    output logic sftQ,
    output logic addsub,
    output logic decr,
    output logic ldcnt,
    output logic busy,
    output logic done
);
    typedef enum logic [2:0] {IDLE, LDM, LDQ, EVAL, SHIFT, DONE} state_t;
    state_t state, nxt;
    if (N < 1) begin : g_bad_n
        $error("booth_controller: N must be positive");
    end
    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE:  nxt = start ? LDM : IDLE;
            LDM:   nxt = LDQ;
            LDQ:   nxt = EVAL;
            EVAL:  nxt = eqz ? DONE : SHIFT;
            SHIFT: nxt = EVAL;
            default: nxt = IDLE;
        endcase
    end
`ifdef BOOTH_ABORT_EN
    logic abort_ok;
    assign abort_ok = abort && state != IDLE && state != DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            aborted <= 1'b0;
        end else begin
            state   <= abort_ok ? IDLE : nxt;
            aborted <= abort_ok;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end
`endif
    // q0/qm1 only matter while evaluating a live iteration
    logic ev;
    assign ev     = state == EVAL && !eqz;
    assign ldA    = ev && (q0 ^ qm1);
    assign addsub = ev && !q0 && qm1;
    assign ldM    = state == LDM;
    assign clrA   = state == LDM;
    assign clrff  = state == LDM;
    assign ldcnt  = state == LDM;
    assign clrQ   = 1'b0;
    assign ldQ    = state == LDQ;
    assign sftA   = state == SHIFT;
    assign sftQ   = state == SHIFT;
    assign decr   = state == SHIFT;
    assign busy   = state != IDLE;
    assign done   = state == DONE;
endmodule
